hazard_ctrl: RTL



---
 rtl/hazard_pkg.sv | 56 +++++
 rtl/haz_match.sv | 20 ++
 rtl/hazard_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared codes, widths, stage-entry struct and Tnew helpers for the hazard controller.
package hazard_pkg;

  localparam int unsigned RES_W  = 3;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned TNEW_W = 2;
  localparam int unsigned SEL_W  = 2;

  // Result classes; codes 5-7 behave as no-write.
  localparam logic [RES_W-1:0] RES_NW  = RES_W'(0);
  localparam logic [RES_W-1:0] RES_ALU = RES_W'(1);
  localparam logic [RES_W-1:0] RES_DM  = RES_W'(2);
  localparam logic [RES_W-1:0] RES_PC  = RES_W'(3);
  localparam logic [RES_W-1:0] RES_MD  = RES_W'(4);

  // Forwarding mux selects.
  localparam logic [SEL_W-1:0] FWD_RF = SEL_W'(0);
  localparam logic [SEL_W-1:0] FWD_E  = SEL_W'(1);
  localparam logic [SEL_W-1:0] FWD_M  = SEL_W'(2);
  localparam logic [SEL_W-1:0] FWD_W  = SEL_W'(3);

  // Tuse value meaning "operand not consumed"; never below any Tnew.
  localparam logic [TNEW_W-1:0] TUSE_NONE = TNEW_W'(3);

  typedef struct packed {
    logic [REG_W-1:0]  wa;
    logic [RES_W-1:0]  res;
    logic [TNEW_W-1:0] tnew;
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '0;

  function automatic logic res_writes(input logic [RES_W-1:0] res);
    return (res == RES_ALU) || (res == RES_DM) || (res == RES_PC) || (res == RES_MD);
  endfunction

  function automatic logic [RES_W-1:0] res_norm(input logic [RES_W-1:0] res);
    return res_writes(res) ? res : RES_NW;
  endfunction

  function automatic logic [TNEW_W-1:0] tnew_of(input logic [RES_W-1:0] res);
    logic [TNEW_W-1:0] t;
    case (res)
      RES_ALU: t = TNEW_W'(1);
      RES_DM:  t = TNEW_W'(2);
      RES_MD:  t = TNEW_W'(1);
      default: t = TNEW_W'(0);
    endcase
    return t;
  endfunction

  function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - TNEW_W'(1);
  endfunction

endpackage

// File: rtl/haz_match.sv
// Compares one source register and its Tuse against one tracked stage entry.
module haz_match
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0]  src_i,
  input  logic [TNEW_W-1:0] tuse_i,
  input  stage_t            stg_i,
  output logic              match_o,
  output logic              need_stall_o,
  output logic              can_fwd_o
);

  // Match ignores r0 and non-writing classes; forwarding only once the value exists.
  always_comb begin
    match_o      = (src_i != '0) && (stg_i.wa == src_i) && res_writes(stg_i.res);
    need_stall_o = match_o && (tuse_i < stg_i.tnew);
    can_fwd_o    = match_o && (stg_i.tnew == '0);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: tracks E/M/W producers, drives stall and D/E forwarding selects.
// Optional HAZ_MULDIV_EN adds md_busy/md_op_D and stalls mult/div users behind a busy unit.
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [REG_W-1:0]  rs_D,
  input  logic [REG_W-1:0]  rt_D,
  input  logic [TNEW_W-1:0] tuse_rs_D,
  input  logic [TNEW_W-1:0] tuse_rt_D,
  input  logic [REG_W-1:0]  wa_D,
  input  logic [RES_W-1:0]  Res_D,
`ifdef HAZ_MULDIV_EN
  input  logic              md_busy,
  input  logic              md_op_D,
`endif
  output logic              stall,
  output logic [SEL_W-1:0]  fwd_rs_D,
  output logic [SEL_W-1:0]  fwd_rt_D,
  output logic [SEL_W-1:0]  fwd_rs_E,
  output logic [SEL_W-1:0]  fwd_rt_E,
  output logic [RES_W-1:0]  Res_E_o
);

  localparam int unsigned N_SRC = 2;
  localparam int unsigned N_STG = 3;

  stage_t           e_q, e_d, m_q, m_d, w_q, w_d;
  logic [REG_W-1:0] rs_e_q, rs_e_d, rt_e_q, rt_e_d;

  stage_t            stg [N_STG];
  logic [REG_W-1:0]  d_src [N_SRC];
  logic [TNEW_W-1:0] d_tuse [N_SRC];
  logic [REG_W-1:0]  e_src [N_SRC];

  logic [N_SRC-1:0][N_STG-1:0]   d_match, d_stall, d_fwd;
  logic [N_SRC-1:0][N_STG-2:0]   e_match, e_fwd, unused_e_stall;
  logic [N_SRC-1:0][SEL_W-1:0]   sel_d, sel_e;

  assign stg[0]    = e_q;
  assign stg[1]    = m_q;
  assign stg[2]    = w_q;
  assign d_src[0]  = rs_D;
  assign d_src[1]  = rt_D;
  assign d_tuse[0] = tuse_rs_D;
  assign d_tuse[1] = tuse_rt_D;
  assign e_src[0]  = rs_e_q;
  assign e_src[1]  = rt_e_q;

  // One comparator per source per stage; E-stage sources only look at M and W.
  for (genvar s = 0; s < N_SRC; s++) begin : g_src
    for (genvar g = 0; g < N_STG; g++) begin : g_d
      haz_match u_d (
        .src_i        (d_src[s]),
        .tuse_i       (d_tuse[s]),
        .stg_i        (stg[g]),
        .match_o      (d_match[s][g]),
        .need_stall_o (d_stall[s][g]),
        .can_fwd_o    (d_fwd[s][g])
      );
    end
    for (genvar g = 0; g < N_STG - 1; g++) begin : g_e
      haz_match u_e (
        .src_i        (e_src[s]),
        .tuse_i       (TUSE_NONE),
        .stg_i        (stg[g+1]),
        .match_o      (e_match[s][g]),
        .need_stall_o (unused_e_stall[s][g]),
        .can_fwd_o    (e_fwd[s][g])
      );
    end
  end

  // Stall: W never needs one since its Tnew is always zero.
  always_comb begin
    stall = |d_stall;
`ifdef HAZ_MULDIV_EN
    if (md_op_D && (md_busy || (e_q.res == RES_MD))) stall = 1'b1;
`endif
  end

  // Newest matching stage decides; a not-yet-ready newest match selects RF.
  always_comb begin
    sel_d = '0;
    sel_e = '0;
    for (int s = 0; s < int'(N_SRC); s++) begin
      if (d_match[s][0])      sel_d[s] = d_fwd[s][0] ? FWD_E : FWD_RF;
      else if (d_match[s][1]) sel_d[s] = d_fwd[s][1] ? FWD_M : FWD_RF;
      else if (d_match[s][2]) sel_d[s] = d_fwd[s][2] ? FWD_W : FWD_RF;
      if (e_match[s][0])      sel_e[s] = e_fwd[s][0] ? FWD_M : FWD_RF;
      else if (e_match[s][1]) sel_e[s] = e_fwd[s][1] ? FWD_W : FWD_RF;
    end
  end

  assign fwd_rs_D = sel_d[0];
  assign fwd_rt_D = sel_d[1];
  assign fwd_rs_E = sel_e[0];
  assign fwd_rt_E = sel_e[1];
  assign Res_E_o  = e_q.res;

  // Tag advance: M and W always shift, E takes the D tags or a bubble on stall.
  always_comb begin
    m_d      = e_q;
    m_d.tnew = tnew_dec(e_q.tnew);
    w_d      = m_q;
    w_d.tnew = tnew_dec(m_q.tnew);
    e_d      = STAGE_BUBBLE;
    rs_e_d   = '0;
    rt_e_d   = '0;
    if (!stall) begin
      e_d.wa   = wa_D;
      e_d.res  = res_norm(Res_D);
      e_d.tnew = tnew_of(res_norm(Res_D));
      rs_e_d   = rs_D;
      rt_e_d   = rt_D;
    end
  end

  // Stage tag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_q    <= STAGE_BUBBLE;
      m_q    <= STAGE_BUBBLE;
      w_q    <= STAGE_BUBBLE;
      rs_e_q <= '0;
      rt_e_q <= '0;
    end else begin
      e_q    <= e_d;
      m_q    <= m_d;
      w_q    <= w_d;
      rs_e_q <= rs_e_d;
      rt_e_q <= rt_e_d;
    end
  end

endmodule
